// File: rtl/shift_add_multiplier_seq.sv
// Sequential shift-and-add multiplier: one multiplier bit per cycle, LSB first.
// Signed mode multiplies magnitudes and applies the product sign at completion.
module shift_add_multiplier_seq #(
    parameter int unsigned DATA_WIDTH_A = 8,
    parameter int unsigned DATA_WIDTH_B = 8,
    parameter int unsigned DATA_WIDTH_C = DATA_WIDTH_A + DATA_WIDTH_B,
    parameter int unsigned SIGNED       = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [DATA_WIDTH_A-1:0] i_a,
    input  logic [DATA_WIDTH_B-1:0] i_b,
    input  logic                    i_valid,
    output logic                    o_accept,
    output logic                    o_busy,
    output logic [DATA_WIDTH_C-1:0] o_c,
    output logic                    o_done
);

    localparam int unsigned CntW = (DATA_WIDTH_B > 1) ? $clog2(DATA_WIDTH_B) : 1;

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e                  state_q;
    logic [CntW-1:0]         cnt_q;
    logic [DATA_WIDTH_C-1:0] acc_q;
    logic [DATA_WIDTH_A-1:0] mcand_q;
    logic [DATA_WIDTH_B-1:0] mplier_q;
    logic                    sign_q;

    logic                    a_neg;
    logic                    b_neg;
    logic [DATA_WIDTH_A-1:0] a_mag;
    logic [DATA_WIDTH_B-1:0] b_mag;
    logic [DATA_WIDTH_C-1:0] addend;
    logic [DATA_WIDTH_C-1:0] acc_sum;
    logic [DATA_WIDTH_C-1:0] result;
    logic                    last_iter;

    // Operand magnitudes, partial-product addend and signed final result.
    always_comb begin
        a_neg     = (SIGNED != 0) && i_a[DATA_WIDTH_A-1];
        b_neg     = (SIGNED != 0) && i_b[DATA_WIDTH_B-1];
        // Unsigned at full width, so the most negative operand maps exactly.
        a_mag     = a_neg ? (~i_a + DATA_WIDTH_A'(1)) : i_a;
        b_mag     = b_neg ? (~i_b + DATA_WIDTH_B'(1)) : i_b;
        addend    = mplier_q[0] ? (DATA_WIDTH_C'(mcand_q) << cnt_q) : '0;
        acc_sum   = acc_q + addend;
        // Negating a zero magnitude yields zero, so no special case is needed.
        result    = sign_q ? (~acc_sum + DATA_WIDTH_C'(1)) : acc_sum;
        last_iter = (cnt_q == CntW'(DATA_WIDTH_B - 1));
    end

    assign o_accept = (state_q == StIdle);

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_c      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    o_done <= 1'b0;
                    if (i_valid) begin
                        state_q  <= StBusy;
                        o_busy   <= 1'b1;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        sign_q   <= a_neg ^ b_neg;
                    end
                end
                StBusy: begin
                    acc_q    <= acc_sum;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CntW'(1);
                    // Always runs the full DATA_WIDTH_B iterations for fixed latency.
                    if (last_iter) begin
                        state_q <= StIdle;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        o_c     <= result;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier_seq.sv
// Scoreboard bench: two 8x8 DUTs (unsigned/signed) share one stimulus group and
// two 4x12 DUTs (unsigned/signed) share another; a timing model pushes expected
// products on accept and a negedge monitor pops them on o_done.
module tb_shift_add_multiplier_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, v0;
    logic [7:0]  a0, b0;
    logic        rst1, v1;
    logic [3:0]  a1;
    logic [11:0] b1;

    logic [15:0] c    [4];
    logic        done [4];
    logic        busy [4];
    logic        acc  [4];

    shift_add_multiplier_seq #(.DATA_WIDTH_A(8), .DATA_WIDTH_B(8), .SIGNED(0)) dut_u8 (
        .i_clk(clk), .i_rst(rst0), .i_a(a0), .i_b(b0), .i_valid(v0),
        .o_accept(acc[0]), .o_busy(busy[0]), .o_c(c[0]), .o_done(done[0])
    );
    shift_add_multiplier_seq #(.DATA_WIDTH_A(8), .DATA_WIDTH_B(8), .SIGNED(1)) dut_s8 (
        .i_clk(clk), .i_rst(rst0), .i_a(a0), .i_b(b0), .i_valid(v0),
        .o_accept(acc[1]), .o_busy(busy[1]), .o_c(c[1]), .o_done(done[1])
    );
    shift_add_multiplier_seq #(.DATA_WIDTH_A(4), .DATA_WIDTH_B(12), .SIGNED(0)) dut_u4 (
        .i_clk(clk), .i_rst(rst1), .i_a(a1), .i_b(b1), .i_valid(v1),
        .o_accept(acc[2]), .o_busy(busy[2]), .o_c(c[2]), .o_done(done[2])
    );
    shift_add_multiplier_seq #(.DATA_WIDTH_A(4), .DATA_WIDTH_B(12), .SIGNED(1)) dut_s4 (
        .i_clk(clk), .i_rst(rst1), .i_a(a1), .i_b(b1), .i_valid(v1),
        .o_accept(acc[3]), .o_busy(busy[3]), .o_c(c[3]), .o_done(done[3])
    );

    // Directed 8x8 vectors: a, b, hand-computed unsigned and signed products.
    logic [7:0]  ta  [8] = '{8'hFF, 8'h80, 8'h80, 8'h00, 8'h03, 8'hFE, 8'h7F, 8'h0C};
    logic [7:0]  tb  [8] = '{8'hFF, 8'h80, 8'h7F, 8'hFB, 8'h05, 8'h03, 8'h7F, 8'hF6};
    logic [15:0] teu [8] = '{16'hFE01, 16'h4000, 16'h3F80, 16'h0000,
                             16'h000F, 16'h02FA, 16'h3F01, 16'h0B88};
    logic [15:0] tes [8] = '{16'h0001, 16'h4000, 16'hC080, 16'h0000,
                             16'h000F, 16'hFFFA, 16'h3F01, 16'hFF88};

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q  [4][$];
    logic [15:0] last_c [4];
    bit          m_busy [2];
    bit          m_done [2];
    int          m_cnt  [2];
    bit          mon_en   = 1'b0;
    int          acc_cnt1 = 0;
    logic [15:0] exp_u0, exp_s0;

    function automatic logic [15:0] ref4(input logic [3:0] a, input logic [11:0] b,
                                         input bit sgn);
        int ia, ib;
        ia = (sgn && a[3])  ? int'(a) - 16   : int'(a);
        ib = (sgn && b[11]) ? int'(b) - 4096 : int'(b);
        return 16'(ia * ib);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input int g, input bit r, input bit v, input int nb);
        m_done[g] = 1'b0;
        if (r) begin
            m_busy[g] = 1'b0;
            m_cnt[g]  = 0;
            for (int k = 2 * g; k < 2 * g + 2; k++) begin
                exp_q[k].delete();
                last_c[k] = 16'h0;
            end
        end else if (m_busy[g]) begin
            if (m_cnt[g] == nb - 1) begin
                m_busy[g] = 1'b0;
                m_done[g] = 1'b1;
            end else begin
                m_cnt[g]++;
            end
        end else if (v) begin
            m_busy[g] = 1'b1;
            m_cnt[g]  = 0;
            if (g == 0) begin
                exp_q[0].push_back(exp_u0);
                exp_q[1].push_back(exp_s0);
            end else begin
                exp_q[2].push_back(ref4(a1, b1, 1'b0));
                exp_q[3].push_back(ref4(a1, b1, 1'b1));
                acc_cnt1++;
            end
        end
    endtask

    // Reference timing model; reads only bench-driven inputs.
    always @(posedge clk) begin
        model_step(0, rst0, v0, 8);
        model_step(1, rst1, v1, 12);
    end

    // Monitor: protocol timing against the model, products against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 4; d++) begin
                int g;
                logic [15:0] e;
                g = d / 2;
                check($sformatf("d%0d accept", d), 32'(acc[d]), 32'(!m_busy[g]));
                check($sformatf("d%0d busy", d), 32'(busy[d]), 32'(m_busy[g]));
                check($sformatf("d%0d done", d), 32'(done[d]), 32'(m_done[g]));
                if (done[d] === 1'b1) begin
                    if (exp_q[d].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL d%0d unexpected_done: got o_c %0h expected none", d, c[d]);
                    end else begin
                        e = exp_q[d].pop_front();
                        check($sformatf("d%0d product", d), 32'(c[d]), 32'(e));
                        last_c[d] = e;
                    end
                end
                check($sformatf("d%0d hold", d), 32'(c[d]), 32'(last_c[d]));
            end
        end
    end

    task automatic op0(input int i);
        @(negedge clk);
        a0 = ta[i]; b0 = tb[i]; exp_u0 = teu[i]; exp_s0 = tes[i];
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        a0 = 8'($urandom);
        b0 = 8'($urandom);
        repeat (9) @(negedge clk);
    endtask

    initial begin
        int guard;
        rst0 = 1'b1; rst1 = 1'b1; v0 = 1'b0; v1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; exp_u0 = '0; exp_s0 = '0;
        for (int d = 0; d < 4; d++) last_c[d] = 16'h0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // Reset wins over a simultaneous request.
        v0 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0; v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        check("post_reset accept", 32'(acc[0]), 32'd1);

        for (int i = 0; i < 8; i++) op0(i);

        // Request held high with operands changing every cycle.
        @(negedge clk);
        v0 = 1'b1;
        for (int k = 0; k < 36; k++) begin
            a0 = ta[k % 8]; b0 = tb[k % 8]; exp_u0 = teu[k % 8]; exp_s0 = tes[k % 8];
            @(negedge clk);
        end
        v0 = 1'b0;
        repeat (10) @(negedge clk);

        // Reset in the 4th busy cycle aborts the operation.
        a0 = ta[2]; b0 = tb[2]; exp_u0 = teu[2]; exp_s0 = tes[2];
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        repeat (3) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        check("abort o_c", 32'(c[0]), 32'h0);
        check("abort accept", 32'(acc[1]), 32'd1);
        op0(6);

        // 4x12 random operands, both modes in parallel.
        @(negedge clk);
        v1 = 1'b1;
        guard = 0;
        while (acc_cnt1 < 1000 && guard < 20000) begin
            a1 = 4'($urandom);
            b1 = 12'($urandom);
            guard++;
            @(negedge clk);
        end
        v1 = 1'b0;
        check("random accepts", 32'(acc_cnt1), 32'd1000);
        repeat (14) @(negedge clk);

        for (int d = 0; d < 4; d++)
            check($sformatf("d%0d drain", d), 32'(exp_q[d].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier_seq.md
SHIFT_ADD_MULTIPLIER_SEQ -- requirements
Module: shift_add_multiplier_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_WIDTH_A, default 8: width of multiplicand i_a; legal range 2..32.
REQ-003 Parameter DATA_WIDTH_B, default 8: width of multiplier i_b and the iteration count; legal range 2..32.
REQ-004 Parameter DATA_WIDTH_C, default DATA_WIDTH_A+DATA_WIDTH_B: width of product o_c; only the default value is supported.
REQ-005 Parameter SIGNED, default 0: 0 means unsigned operands; 1 means two's-complement operands and product.
REQ-006 Port i_clk, input, 1: clock; all state updates on its rising edge.
REQ-007 Port i_rst, input, 1: synchronous active-high reset.
REQ-008 Port i_a, input, DATA_WIDTH_A: multiplicand, sampled only on the accept edge.
REQ-009 Port i_b, input, DATA_WIDTH_B: multiplier, sampled only on the accept edge.
REQ-010 Port i_valid, input, 1: request to start a multiplication.
REQ-011 Port o_accept, output, 1: combinational, equal to (state==IDLE); high means the request is taken this edge.
REQ-012 Port o_busy, output, 1: registered, high while state==BUSY.
REQ-013 Port o_c, output, DATA_WIDTH_C: registered product; holds its value until the next completion.
REQ-014 Port o_done, output, 1: registered one-cycle pulse marking a new valid o_c.

Function
REQ-015 The block SHALL have two states: IDLE and BUSY.
REQ-016 An accept SHALL occur on a rising edge where i_valid=1 and state==IDLE; the block then goes IDLE->BUSY, iteration counter=0, accumulator=0.
REQ-017 On the accept edge with SIGNED=1, the block SHALL latch |i_a|, |i_b| and sign=msb(i_a) XOR msb(i_b); with SIGNED=0 it SHALL latch raw values and sign=0.
REQ-018 Magnitudes SHALL be held unsigned at full operand width, so |-2^(W-1)| = 2^(W-1) is exact.
REQ-019 Each BUSY cycle SHALL consume one multiplier bit, LSB first: if the bit is 1, add the multiplicand shifted by the counter value into the DATA_WIDTH_C accumulator; the counter then increments.
REQ-020 The accumulator SHALL NOT overflow, because the full-width magnitude product always fits in DATA_WIDTH_C.
REQ-021 BUSY SHALL last exactly DATA_WIDTH_B cycles with no early termination, including when an operand is zero.
REQ-022 On the edge ending the last BUSY cycle, o_c SHALL load the accumulator result, two's-complement negated when sign=1; o_done SHALL be 1 for one cycle, o_busy 0, and state IDLE.
REQ-023 Latency SHALL be fixed: o_done is high in the cycle that starts DATA_WIDTH_B rising edges after the accept edge.
REQ-024 i_valid SHALL be ignored while BUSY; i_a and i_b changes after the accept edge SHALL NOT affect the result.
REQ-025 o_accept SHALL be high during the o_done cycle, so back-to-back operation completes one product per DATA_WIDTH_B+1 cycles.
REQ-026 A zero product with sign=1 SHALL give o_c=0.

Reset
REQ-027 While i_rst=1 at a rising edge: state=IDLE, o_busy=0, o_done=0, o_c=0, accumulator=0, counter=0.
REQ-028 i_rst SHALL take priority over i_valid on the same edge, and no accept SHALL occur on that edge.
REQ-029 Reset during BUSY SHALL abort the operation, produce no o_done, and clear o_c to 0.
REQ-030 After reset deasserts, o_accept SHALL be high in the first cycle.

Verification
REQ-031 The bench SHALL cover: unsigned, A=B=8, i_a=255, i_b=255 -> o_done 8 cycles after accept, o_c=65025.
REQ-032 The bench SHALL cover: SIGNED=1, A=B=8, i_a=-128, i_b=-128 -> o_c=16384; then i_a=-128, i_b=127 -> o_c=-16256 (16'hC080).
REQ-033 The bench SHALL cover: SIGNED=1, i_a=0, i_b=-5 -> o_c=0 after the full 8 BUSY cycles.
REQ-034 The bench SHALL cover: i_valid held high continuously with i_a/i_b changing every cycle -> only the accept-edge operands are used, one o_done per 9 cycles, o_accept low during BUSY.
REQ-035 The bench SHALL cover: i_rst pulsed at the 4th BUSY cycle -> no o_done, o_c=0, o_accept=1 on the next cycle, and the next request gives a correct product.
REQ-036 The bench SHALL cover: A=4, B=12, with 1000 random operands in each SIGNED mode -> o_c matches the reference product and the latency is always 12.
